gpr_file: RTL

Parametrised general-purpose register file with one write port, two independent read ports and a cs/rdy request handshake. It replaces the single-port, tri-state-bus register block with separate unidirectional data buses, synchronous reset, range checking and a read-valid strobe. It sits between the instruction decode/control FSM and the ALU operand latches.

---
 rtl/gpr_pkg.sv | 24 ++
 rtl/gpr_array.sv | 58 +++++
 rtl/gpr_file.sv | 115 +++++++++++
 3 files changed

// File: rtl/gpr_pkg.sv
// Shared types and default sizing for the general-purpose register file.
package gpr_pkg;

  localparam int unsigned GPR_DATA_WIDTH = 16;
  localparam int unsigned GPR_ADDR_WIDTH = 3;
  localparam int unsigned GPR_DEPTH      = 8;

  // Request payload is sized for the widest supported build; instances zero-extend into it.
  localparam int unsigned GPR_MAX_DW = 64;
  localparam int unsigned GPR_MAX_AW = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } gpr_state_e;

  typedef struct packed {
    logic                  wr;
    logic [GPR_MAX_AW-1:0] addr_a;
    logic [GPR_MAX_AW-1:0] addr_b;
    logic [GPR_MAX_DW-1:0] wdata;
  } gpr_req_t;

endpackage

// File: rtl/gpr_array.sv
// Register storage: one synchronous write port, two registered read ports with zero-force.
// Optional build macro GPR_ZERO_REG_EN hardwires register 0 to zero.
module gpr_array
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int unsigned DEPTH      = GPR_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  input  logic                  zero_a,
  input  logic                  zero_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  we_c;
  logic                  zero_a_c;
  logic                  zero_b_c;

`ifdef GPR_ZERO_REG_EN
  // Register 0 never stores and always reads back as zero.
  assign we_c     = we && (waddr != '0);
  assign zero_a_c = zero_a || (raddr_a == '0);
  assign zero_b_c = zero_b || (raddr_b == '0);
`else
  assign we_c     = we;
  assign zero_a_c = zero_a;
  assign zero_b_c = zero_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (we_c) begin
        mem_q[waddr] <= wdata;
      end
      if (re) begin
        rdata_a <= zero_a_c ? '0 : mem_q[raddr_a];
        rdata_b <= zero_b_c ? '0 : mem_q[raddr_b];
      end
    end
  end

endmodule

// File: rtl/gpr_file.sv
// Register file front end: cs/rdy handshake FSM, request capture, range check, valid/err strobes.
// Optional build macro GPR_ZERO_REG_EN (handled in gpr_array) hardwires register 0 to zero.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
  parameter int unsigned DEPTH      = GPR_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rdy,
  output logic                  valid,
  output logic                  err
);

  gpr_state_e state_q, state_d;
  gpr_req_t   req_q, req_d;
  logic       rdy_q, rdy_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic       a_oor_c;
  logic       b_oor_c;
  logic       we_c;
  logic       re_c;
  logic       req_unused_c;

  assign a_oor_c = 32'(req_q.addr_a) >= DEPTH;
  assign b_oor_c = 32'(req_q.addr_b) >= DEPTH;

  // Upper payload bits exist only for wider builds.
  assign req_unused_c = ^req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdy_q   <= rdy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdy_d   = 1'b1;
    valid_d = 1'b0;
    err_d   = 1'b0;
    we_c    = 1'b0;
    re_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs) begin
          req_d.wr     = wr;
          req_d.addr_a = GPR_MAX_AW'(addr_a);
          req_d.addr_b = GPR_MAX_AW'(addr_b);
          req_d.wdata  = GPR_MAX_DW'(wdata);
          state_d      = ACCESS;
          rdy_d        = 1'b0;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (req_q.wr) begin
          we_c  = !a_oor_c;
          err_d = a_oor_c;
        end else begin
          re_c    = 1'b1;
          valid_d = 1'b1;
          err_d   = a_oor_c || b_oor_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  gpr_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (we_c),
    .waddr  (ADDR_WIDTH'(req_q.addr_a)),
    .wdata  (DATA_WIDTH'(req_q.wdata)),
    .re     (re_c),
    .raddr_a(ADDR_WIDTH'(req_q.addr_a)),
    .raddr_b(ADDR_WIDTH'(req_q.addr_b)),
    .zero_a (a_oor_c),
    .zero_b (b_oor_c),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b)
  );

  assign rdy   = rdy_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule
